// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_seq_pkg;

    // Sequencer phases: initial hold, staggered release, steady state.
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_t;

    // Ceiling log2 for sizing index registers from elaboration constants.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronises the asynchronous reset request and debounces its rising side.
// Latency: req_db rises DEBOUNCE_CLKS+1 clocks after the first sampled high; falls 2 clocks after input low.
// Backpressure: none; level in, level out.
//
// Ports:
//   clk       - sampling clock
//   rst_n     - asynchronous active-low reset, clears all state
//   req_async - raw external reset request (active high, any timing)
//   req_db    - debounced request, registered
module sync_debounce #(
    parameter int DEBOUNCE_CLKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_async,
    output logic req_db
);

    if (DEBOUNCE_CLKS < 1 || DEBOUNCE_CLKS > 255) begin : g_bad_debounce
        $error("sync_debounce: DEBOUNCE_CLKS must be 1..255");
    end

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CLKS - 1);
    localparam logic [7:0] DEB_ONE  = 8'd1;

    logic       meta;
    logic       sync;
    logic [7:0] deb_cnt;

    // Assertion is debounced; release is taken on the first low sample so a
    // restarted sequence is not delayed any further than necessary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            deb_cnt <= '0;
            req_db  <= 1'b0;
        end else begin
            meta <= req_async;
            sync <= meta;
            if (!sync) begin
                deb_cnt <= '0;
                req_db  <= 1'b0;
            end else if (deb_cnt == DEB_LAST) begin
                req_db  <= 1'b1;
            end else begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset generator: holds N channels in reset, then releases them in staggered order.
// Latency: channel k releases at edge CLKS_PER_RESET+1+k*CLKS_BETWEEN after reset_n or request release.
// Backpressure: none; a debounced reset_req restarts the sequence from any state.
//
// Ports:
//   fpga_clk  - system clock
//   reset_n   - asynchronous active-low reset
//   reset_req - asynchronous active-high restart request
//   reset_out - per-channel reset, polarity per ACTIVE_LOW_MASK, driven straight from flops
//   seq_done  - every channel released
//   busy      - inverse of seq_done
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                      NUM_CHANNELS    = 4,
    parameter int                      CNT_WIDTH       = 16,
    parameter int                      CLKS_PER_RESET  = 16,
    parameter int                      CLKS_BETWEEN    = 8,
    parameter logic [NUM_CHANNELS-1:0] ACTIVE_LOW_MASK = {NUM_CHANNELS{1'b1}},
    parameter int                      DEBOUNCE_CLKS   = 4
) (
    input  logic                    fpga_clk,
    input  logic                    reset_n,
    input  logic                    reset_req,
    output logic [NUM_CHANNELS-1:0] reset_out,
    output logic                    seq_done,
    output logic                    busy
);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
        $error("reset_sequencer: NUM_CHANNELS must be 1..16");
    end
    if (CLKS_PER_RESET < 0 || (CLKS_PER_RESET >> CNT_WIDTH) != 0) begin : g_bad_hold
        $error("reset_sequencer: CLKS_PER_RESET does not fit in CNT_WIDTH");
    end
    if (CLKS_BETWEEN < 0 || (CLKS_BETWEEN >> CNT_WIDTH) != 0) begin : g_bad_gap
        $error("reset_sequencer: CLKS_BETWEEN does not fit in CNT_WIDTH");
    end

    localparam int                   IDX_W    = (NUM_CHANNELS > 1) ? clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] HOLD_CNT = CNT_WIDTH'(CLKS_PER_RESET);
    localparam logic [CNT_WIDTH-1:0] GAP_CNT  = CNT_WIDTH'(CLKS_BETWEEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // With a single channel or no gap, everything leaves reset on one edge.
    localparam bit RELEASE_ALL = (NUM_CHANNELS == 1) || (CLKS_BETWEEN == 0);

    logic                    req_db;
    seq_state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CHANNELS-1:0] hold_q, hold_d;
    logic                    done_d;

    sync_debounce #(
        .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
    ) u_sync_debounce (
        .clk      (fpga_clk),
        .rst_n    (reset_n),
        .req_async(reset_req),
        .req_db   (req_db)
    );

    // State and registered outputs.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '1;
            reset_out <= ~ACTIVE_LOW_MASK;
            seq_done  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            reset_out <= hold_d ^ ACTIVE_LOW_MASK;
            seq_done  <= done_d;
            busy      <= ~done_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        if (req_db) begin
            state_d = ASSERT;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == HOLD_CNT) begin
                        state_d = RELEASE_ALL ? DONE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_CNT && idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = ASSERT;
            endcase
        end
    end

    // Counter, channel index, hold vector and completion flag.
    // After each staggered release the counter restarts at 1: the release
    // edge itself is the first clock of the next interval, which spaces
    // consecutive releases exactly CLKS_BETWEEN edges apart.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        hold_d = hold_q;
        done_d = seq_done;
        if (req_db) begin
            cnt_d  = '0;
            idx_d  = '0;
            hold_d = '1;
            done_d = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == HOLD_CNT) begin
                        if (RELEASE_ALL) begin
                            hold_d = '0;
                            cnt_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            hold_d[0] = 1'b0;
                            cnt_d     = CNT_ONE;
                            idx_d     = IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_CNT) begin
                        hold_d[idx_q] = 1'b0;
                        cnt_d         = CNT_ONE;
                        idx_d         = idx_q + IDX_ONE;
                        if (idx_q == LAST_IDX) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int         CPR    = 16;
    localparam int         CB_A   = 8;
    localparam int         CB_B   = 0;
    localparam int         DEB    = 4;
    localparam logic [3:0] MASK_A = 4'b0101;
    localparam logic [2:0] MASK_B = 3'b111;

    logic       fpga_clk  = 1'b0;
    logic       reset_n   = 1'b1;
    logic       reset_req = 1'b0;
    logic [3:0] out_a;
    logic       done_a;
    logic       busy_a;
    logic [2:0] out_b;
    logic       done_b;
    logic       busy_b;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];

    // Reference model state: edges since the sequence origin, length of the
    // current run of high synchronised samples, and the debounced request.
    int       t_m     = 0;
    int       run_m   = 0;
    bit       db_m    = 1'b0;
    bit [1:0] rpipe_m = 2'b00;

    always #5 fpga_clk = ~fpga_clk;

    reset_sequencer #(
        .NUM_CHANNELS   (4),
        .CNT_WIDTH      (16),
        .CLKS_PER_RESET (CPR),
        .CLKS_BETWEEN   (CB_A),
        .ACTIVE_LOW_MASK(MASK_A),
        .DEBOUNCE_CLKS  (DEB)
    ) dut_a (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .reset_req(reset_req),
        .reset_out(out_a),
        .seq_done (done_a),
        .busy     (busy_a)
    );

    reset_sequencer #(
        .NUM_CHANNELS   (3),
        .CNT_WIDTH      (16),
        .CLKS_PER_RESET (CPR),
        .CLKS_BETWEEN   (CB_B),
        .ACTIVE_LOW_MASK(MASK_B),
        .DEBOUNCE_CLKS  (DEB)
    ) dut_b (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .reset_req(reset_req),
        .reset_out(out_b),
        .seq_done (done_b),
        .busy     (busy_b)
    );

    // Channel k is out of reset once tt >= CPR+1+k*gap, unless a request holds it.
    function automatic logic [10:0] model_out(input int tt, input bit held);
        logic [3:0] ha;
        logic [2:0] hb;
        logic       da;
        logic       dbv;
        for (int k = 0; k < 4; k++) ha[k] = held || (tt < CPR + 1 + k * CB_A);
        for (int k = 0; k < 3; k++) hb[k] = held || (tt < CPR + 1 + k * CB_B);
        da  = (ha == 4'b0000);
        dbv = (hb == 3'b000);
        return {~da, da, ha ^ MASK_A, ~dbv, dbv, hb ^ MASK_B};
    endfunction

    // Model: one expected output word per clock edge.
    always @(posedge fpga_clk) begin
        bit db_prev;
        bit s;
        if (!reset_n) begin
            t_m     = 0;
            run_m   = 0;
            db_m    = 1'b0;
            rpipe_m = 2'b00;
            exp_q.push_back(model_out(0, 1'b1));
        end else begin
            db_prev = db_m;
            s       = rpipe_m[1];
            rpipe_m = {rpipe_m[0], reset_req};
            run_m   = s ? run_m + 1 : 0;
            db_m    = (run_m >= DEB);
            t_m     = db_prev ? 0 : t_m + 1;
            exp_q.push_back(model_out(t_m, db_prev));
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge fpga_clk) begin
        logic [10:0] got;
        logic [10:0] want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {busy_a, done_a, out_a, busy_b, done_b, out_b};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL scoreboard t=%0t got=%b want=%b", $time, got, want);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            @(negedge fpga_clk);
            #1;
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        check("reset_out_a", 32'(out_a), 'b1010);
        check("reset_out_b", 32'(out_b), 'b000);
        check("reset_done",  32'({done_a, done_b}), 'b00);
        check("reset_busy",  32'({busy_a, busy_b}), 'b11);
        tick(3);
        reset_n = 1'b1;

        // Plain power-on sequence with edge-accurate spot checks.
        for (int e = 1; e <= 45; e++) begin
            tick(1);
            case (e)
                16: check("a_edge16", 32'(out_a), 'b1010);
                17: begin
                    check("a_edge17", 32'(out_a), 'b1011);
                    check("b_edge17", 32'(out_b), 'b111);
                    check("b_done17", 32'(done_b), 1);
                end
                24: check("a_edge24", 32'(out_a), 'b1011);
                25: check("a_edge25", 32'(out_a), 'b1001);
                33: check("a_edge33", 32'(out_a), 'b1101);
                40: check("a_done40", 32'(done_a), 0);
                41: begin
                    check("a_edge41", 32'(out_a), 'b0101);
                    check("a_done41", 32'(done_a), 1);
                    check("a_busy41", 32'(busy_a), 0);
                end
                default: ;
            endcase
        end

        // Short request in DONE is filtered out.
        reset_req = 1'b1;
        tick(3);
        reset_req = 1'b0;
        tick(20);
        check("short_req_ignored", 32'(out_a), 'b0101);

        // Ten-clock request: first sampled at edge k, reassertion at k+6.
        reset_req = 1'b1;
        tick(6);
        check("req_edge_k5", 32'(out_a), 'b0101);
        tick(1);
        check("req_edge_k6", 32'(out_a), 'b1010);
        check("req_done_k6", 32'(done_a), 0);
        tick(3);
        reset_req = 1'b0;
        tick(19);
        check("rerelease_k28", 32'(out_a), 'b1010);
        tick(1);
        check("rerelease_k29", 32'(out_a), 'b1011);
        tick(30);

        // Restart, then a request at edge 30 aborts the running sequence.
        reset_n = 1'b0;
        #1;
        check("async_out_a", 32'(out_a), 'b1010);
        check("async_done", 32'({done_a, done_b}), 'b00);
        tick(2);
        reset_n = 1'b1;
        tick(29);
        reset_req = 1'b1;
        tick(6);
        check("abort_edge35", 32'(out_a), 'b1101);
        tick(1);
        check("abort_edge36", 32'(out_a), 'b1010);
        tick(3);
        reset_req = 1'b0;
        tick(60);

        // reset_n pulsed mid-RELEASE.
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(28);
        reset_n = 1'b0;
        #1;
        check("midrel_out_a", 32'(out_a), 'b1010);
        check("midrel_busy", 32'({busy_a, done_a}), 'b10);
        tick(2);
        reset_n = 1'b1;
        tick(17);
        check("midrel_edge17", 32'(out_a), 'b1011);
        tick(30);

        // Random request bursts and occasional reset pulses.
        for (int i = 0; i < 40; i++) begin
            reset_req = 1'b1;
            tick($urandom_range(1, 12));
            reset_req = 1'b0;
            tick($urandom_range(1, 60));
            if ($urandom_range(0, 7) == 0) begin
                reset_n = 1'b0;
                tick($urandom_range(1, 3));
                reset_n = 1'b1;
            end
        end
        tick(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
